// File: rtl/bilhete_entrada.sv
// bilhete_entrada: ticket-entry sequencer feeding the lottery checker.
// Collects keypad digits into a buffer with backspace/confirm, replays the
// confirmed ticket as numero/insere pulses spaced by GAP idle cycles, closes
// it with a one-cycle fim_jogo, and locks out entry after MAX_TICKETS.
module bilhete_entrada #(
    parameter int DIGITS      = 5,
    parameter int GAP         = 1,
    parameter int MAX_TICKETS = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] tecla,
    input  logic       tecla_valida,
    input  logic       apaga,
    input  logic       confirma,
    output logic [3:0] numero,
    output logic       insere,
    output logic       fim_jogo,
    output logic       ocupado,
    output logic       erro,
    output logic [2:0] digitos,
    output logic [2:0] bilhetes
);

    typedef enum logic [2:0] {
        COLETA    = 3'd0,
        ENVIA     = 3'd1,
        ESPERA    = 3'd2,
        FIM       = 3'd3,
        BLOQUEADO = 3'd4
    } estado_t;

    localparam logic [2:0] DIG      = 3'(DIGITS);
    localparam logic [2:0] ULTIMO   = 3'(DIGITS - 1);
    localparam logic [2:0] MAXT     = 3'(MAX_TICKETS);
    localparam logic [2:0] GAP_FIM  = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

    estado_t    estado;
    // Eight slots so any 3-bit index is in range; only 0..DIGITS-1 are written.
    logic [3:0] buffer [8];
    logic [2:0] idx;
    logic [2:0] gap_cnt;
    // Set once the final digit has gone out, so ESPERA knows to head to FIM.
    logic       enviado_ultimo;

    // Sequencer: keypad handling, replay to the checker and ticket accounting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado         <= COLETA;
            idx            <= 3'd0;
            gap_cnt        <= 3'd0;
            enviado_ultimo <= 1'b0;
            numero         <= 4'd0;
            insere         <= 1'b0;
            fim_jogo       <= 1'b0;
            ocupado        <= 1'b0;
            erro           <= 1'b0;
            digitos        <= 3'd0;
            bilhetes       <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                buffer[i] <= 4'd0;
            end
        end else begin
            // Strobe outputs are single-cycle unless re-asserted below.
            insere   <= 1'b0;
            fim_jogo <= 1'b0;
            erro     <= 1'b0;

            case (estado)
                COLETA: begin
                    ocupado <= 1'b0;
                    // apaga wins over confirma, which wins over a digit;
                    // losers in the same cycle vanish without erro.
                    if (apaga) begin
                        if (digitos != 3'd0) begin
                            digitos <= digitos - 3'd1;
                        end
                    end else if (confirma) begin
                        if (digitos == DIG) begin
                            estado         <= ENVIA;
                            idx            <= 3'd0;
                            enviado_ultimo <= 1'b0;
                            ocupado        <= 1'b1;
                        end else begin
                            erro <= 1'b1;
                        end
                    end else if (tecla_valida) begin
                        if (tecla <= 4'd9 && digitos < DIG) begin
                            buffer[digitos] <= tecla;
                            digitos         <= digitos + 3'd1;
                        end else begin
                            erro <= 1'b1;
                        end
                    end
                end

                ENVIA: begin
                    numero  <= buffer[idx];
                    insere  <= 1'b1;
                    gap_cnt <= 3'd0;
                    if (idx < ULTIMO) begin
                        idx <= idx + 3'd1;
                    end else begin
                        enviado_ultimo <= 1'b1;
                    end
                    if (GAP > 0) begin
                        estado <= ESPERA;
                    end else if (idx == ULTIMO) begin
                        estado <= FIM;
                    end
                end

                ESPERA: begin
                    // numero deliberately left untouched so it holds.
                    if (gap_cnt == GAP_FIM) begin
                        gap_cnt <= 3'd0;
                        estado  <= enviado_ultimo ? FIM : ENVIA;
                    end else begin
                        gap_cnt <= gap_cnt + 3'd1;
                    end
                end

                FIM: begin
                    numero <= buffer[ULTIMO];
                    // Two phases: first issue fim_jogo, then release ocupado
                    // one edge later so entry never reopens under fim_jogo.
                    if (gap_cnt == 3'd0) begin
                        fim_jogo <= 1'b1;
                        bilhetes <= bilhetes + 3'd1;
                        digitos  <= 3'd0;
                        gap_cnt  <= 3'd1;
                    end else begin
                        gap_cnt <= 3'd0;
                        if (bilhetes == MAXT) begin
                            estado <= BLOQUEADO;
                        end else begin
                            estado  <= COLETA;
                            ocupado <= 1'b0;
                        end
                    end
                end

                BLOQUEADO: begin
                    ocupado <= 1'b1;
                    if (tecla_valida || apaga || confirma) begin
                        erro <= 1'b1;
                    end
                end

                default: begin
                    estado  <= COLETA;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bilhete_entrada.md
# bilhete_entrada

Ticket-entry sequencer upstream of the lottery checker. It collects decimal digits from the keypad strobe interface into a DIGITS-deep buffer, with backspace and confirm support. On confirm it replays the stored ticket to the checker as `numero`/`insere` pulses, then issues a one-cycle `fim_jogo`. It counts submitted tickets and locks out further entry after MAX_TICKETS.

## Interface
- DIGITS, 5: digits per ticket; range 1..7.
- GAP, 1: idle cycles between consecutive `insere` pulses, and between the last `insere` and `fim_jogo`; range 0..7.
- MAX_TICKETS, 5: tickets accepted before lockout; range 1..7.

Ports (clock and reset first):
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- tecla  in  4  keypad digit, qualified by `tecla_valida`.
- tecla_valida  in  1  one-cycle strobe: a digit is offered.
- apaga  in  1  one-cycle strobe: delete the last digit.
- confirma  in  1  one-cycle strobe: submit the ticket.
- numero  out  4  digit presented to the checker.
- insere  out  1  one-cycle strobe: `numero` is valid.
- fim_jogo  out  1  one-cycle strobe: ticket complete.
- ocupado  out  1  high while not accepting keypad input.
- erro  out  1  one-cycle pulse on a rejected strobe.
- digitos  out  3  digits currently buffered.
- bilhetes  out  3  tickets submitted since reset.

## Operation
- Reset values:
  - All outputs 0.
  - Buffer cleared to 0.
  - State COLETA.
  - Send index 0 and gap counter 0.
- All outputs are registered.
- States are COLETA, ENVIA, ESPERA, FIM and BLOQUEADO.
- COLETA, strobe priority `apaga` > `confirma` > `tecla_valida`. Lower-priority strobes in the same cycle are dropped silently, with no `erro`.
  - `apaga` with `digitos`>0: `digitos` decrements.
  - `apaga` with `digitos`==0: no-op, no `erro`.
  - `confirma` with `digitos`==DIGITS: go to ENVIA, send index = 0.
  - `confirma` with `digitos`<DIGITS: `erro`, stay in COLETA.
  - `tecla_valida` with `tecla`<=9 and `digitos`<DIGITS: buffer[`digitos`] <= `tecla`, `digitos` increments.
  - `tecla_valida` with `tecla`>9, or with `digitos`==DIGITS: `erro`; buffer and `digitos` unchanged.
- ENVIA:
  - `numero` <= buffer[idx] and `insere` <= 1 for exactly one cycle.
  - If idx<DIGITS-1: idx increments. Next state is ESPERA when GAP>0, otherwise ENVIA.
  - If idx==DIGITS-1: next state is ESPERA when GAP>0, otherwise FIM. After ESPERA, go to FIM.
- ESPERA:
  - `insere`=0 for GAP cycles.
  - `numero` holds its value.
- FIM:
  - `fim_jogo`=1 for one cycle.
  - `numero` holds buffer[DIGITS-1]; the checker compares the last digit on `fim_jogo`.
  - `bilhetes` increments and `digitos` <= 0.
  - Next state is BLOQUEADO if the new `bilhetes`==MAX_TICKETS, otherwise COLETA.
- BLOQUEADO:
  - Any `tecla_valida`, `apaga` or `confirma` produces `erro`.
  - Exit only via reset.
- Strobes arriving in ENVIA, ESPERA or FIM are ignored with no `erro`.
- `ocupado`=1 in ENVIA, ESPERA, FIM and BLOQUEADO; 0 in COLETA.
- Buffer contents are not cleared after a send. Only `digitos` resets, so stale entries are overwritten as new digits arrive.

## Timing
- Keypad strobe sampled at edge e: `digitos` and `erro` update at e. `erro` is high until e+1.
- `confirma` accepted at edge k:
  - State ENVIA and `ocupado`=1 from k.
  - Digit i `insere` high during [k+1+i·(GAP+1), +1 cycle].
  - `fim_jogo` high during [k+1+DIGITS·(GAP+1), +1 cycle].
  - `ocupado` falls one edge later, unless lockout occurs.
- With defaults: `insere` at k+1, k+3, k+5, k+7, k+9; `fim_jogo` at k+11; back in COLETA at k+12.
- `insere` and `fim_jogo` are never high in the same cycle. No two `insere` pulses are adjacent when GAP>0.
- Reset asserted mid-send:
  - `insere`, `fim_jogo`, `ocupado` and `erro` clear immediately.
  - No partial `fim_jogo` is issued and `bilhetes` is not incremented.
- Reset mid-entry: `digitos` returns to 0 immediately.
- Counters never wrap: `bilhetes` saturates at MAX_TICKETS via BLOQUEADO, and `digitos` is bounded by DIGITS.

## Test plan
- **Full ticket:** enter 5,3,8,2,0 then `confirma` at edge k (defaults) -> `insere` at k+1/3/5/7/9 with `numero`=5/3/8/2/0; `fim_jogo` at k+11 with `numero`=0; `bilhetes`=1; `ocupado` low at k+12.
- **Invalid digit and early confirm:** enter 5,3, then `tecla`=12 -> `erro` pulse, `digitos`=2; `confirma` -> `erro`, no `insere`; `apaga` -> `digitos`=1.
- **Simultaneous strobes:** with `digitos`=5, assert `apaga`+`confirma`+`tecla_valida` together -> `digitos`=4, no send, no `erro`. A sixth digit at `digitos`=5 -> `erro`, buffer unchanged.
- **Lockout:** submit 5 tickets -> `bilhetes`=5, `ocupado` stays 1; a following `tecla_valida` -> `erro`, `digitos` stays 0; reset -> `bilhetes`=0, `ocupado`=0.
- **Reset mid-send:** assert reset at k+4 -> `insere`/`fim_jogo` low from k+4 onward, `bilhetes`=0, state COLETA; keypad strobes during k+1..k+10 of an unreset send are ignored without `erro`.
- **GAP=0, DIGITS=3:** `confirma` at k -> `insere` at k+1, k+2, k+3; `fim_jogo` at k+4.
